// File: rtl/serial_parallel_buffered_pkg.sv
// Shared constants and helpers for the serial/parallel converter pair.
package serial_parallel_buffered_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << result) < 64'(value)) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned WORD_WIDTH_DEFAULT = 8;
    localparam int unsigned COUNT_WIDTH = clog2(WORD_WIDTH_DEFAULT + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = '0;

endpackage

// File: rtl/serial_parallel_bit_counter.sv
// Bit counter for the deserializer: load to 0/1, increment, saturate at WORD_WIDTH.
module serial_parallel_bit_counter
    import serial_parallel_buffered_pkg::clog2;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = clog2(WORD_WIDTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   incr_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   full_o
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = COUNT_WIDTH'(WORD_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            // A word leaving the shift register may coincide with the next word's first bit.
            count_d = incr_i ? CountOne : '0;
        end else if (incr_i && (count_q != CountMax)) begin
            count_d = count_q + CountOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CountMax);

endmodule

// File: rtl/serial_parallel_buffered.sv
// MSB-first deserializer with a one-word holding buffer on a ready/valid parallel output.
module serial_parallel_buffered
    import serial_parallel_buffered_pkg::clog2;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = clog2(WORD_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clock_enable,
    input  logic                  clear,
    input  logic                  serial_in_valid,
    output logic                  serial_in_ready,
    input  logic                  serial_in,
    output logic                  parallel_out_valid,
    input  logic                  parallel_out_ready,
    output logic [WORD_WIDTH-1:0] parallel_out
);

    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [WORD_WIDTH-1:0]  hold_q, hold_d;
    logic                   held_q, held_d;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic                   shift_full;
    logic                   out_free;
    logic                   transfer;
    logic                   accept;
    logic                   consume;

    assign out_free = !held_q || parallel_out_ready;
    assign transfer = clock_enable && shift_full && out_free;

    // Reset gating keeps the serial side from advertising ready while held in reset.
    assign serial_in_ready    = reset_n && clock_enable && (!shift_full || out_free);
    assign parallel_out_valid = held_q && clock_enable;
    assign parallel_out       = hold_q;

    assign accept  = serial_in_valid && serial_in_ready;
    assign consume = parallel_out_valid && parallel_out_ready;

    serial_parallel_bit_counter #(
        .WORD_WIDTH  (WORD_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (clear),
        .load_i  (transfer),
        .incr_i  (accept),
        .count_o (bit_count),
        .full_o  (shift_full)
    );

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        held_d  = held_q;
        if (clear) begin
            shift_d = '0;
            hold_d  = '0;
            held_d  = 1'b0;
        end else begin
            if (accept) begin
                shift_d = transfer ? {{(WORD_WIDTH-1){1'b0}}, serial_in}
                                   : {shift_q[WORD_WIDTH-2:0], serial_in};
            end
            if (transfer) begin
                hold_d = shift_q;
                held_d = 1'b1;
            end else if (consume) begin
                held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            hold_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
            held_q  <= held_d;
        end
    end

endmodule

// File: tb/tb_serial_parallel_buffered.sv
// Directed bench for serial_parallel_buffered with immediate-assertion checks.
module tb_serial_parallel_buffered;

    logic       clock;
    logic       reset_n;
    logic       clock_enable;
    logic       clear;
    logic       serial_in_valid;
    logic       serial_in_ready;
    logic       serial_in;
    logic       parallel_out_valid;
    logic       parallel_out_ready;
    logic [7:0] parallel_out;

    int total = 0;
    int bad   = 0;

    serial_parallel_buffered #(
        .WORD_WIDTH (8)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .clock_enable       (clock_enable),
        .clear              (clear),
        .serial_in_valid    (serial_in_valid),
        .serial_in_ready    (serial_in_ready),
        .serial_in          (serial_in),
        .parallel_out_valid (parallel_out_valid),
        .parallel_out_ready (parallel_out_ready),
        .parallel_out       (parallel_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives the top n bits of w, MSB first, one per cycle; leaves serial_in_valid high.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in_valid = 1'b1;
            serial_in       = w[7-i];
            tick();
        end
    endtask

    initial begin
        logic [7:0] words [3];
        logic [7:0] cur;
        words[0] = 8'h3C;
        words[1] = 8'hC3;
        words[2] = 8'hFF;

        reset_n            = 1'b0;
        clock_enable       = 1'b1;
        clear              = 1'b0;
        serial_in_valid    = 1'b0;
        serial_in          = 1'b0;
        parallel_out_ready = 1'b1;
        #3;
        chk("rst_ready", 16'(serial_in_ready), 16'd0);
        chk("rst_valid", 16'(parallel_out_valid), 16'd0);
        chk("rst_data", 16'(parallel_out), 16'h00);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 16'(serial_in_ready), 16'd1);
        chk("post_rst_count", 16'(dut.bit_count), 16'd0);

        // 1: single word 0xA5
        send_bits(8'hA5, 8);
        serial_in_valid = 1'b0;
        #1;
        chk("t1_not_yet", 16'(parallel_out_valid), 16'd0);
        tick();
        chk("t1_valid", 16'(parallel_out_valid), 16'd1);
        chk("t1_data", 16'(parallel_out), 16'hA5);
        tick();
        chk("t1_drop", 16'(parallel_out_valid), 16'd0);

        // 2: back-to-back 0x3C, 0xC3, 0xFF
        for (int k = 0; k < 24; k++) begin
            cur             = words[k/8];
            serial_in_valid = 1'b1;
            serial_in       = cur[7-(k%8)];
            #1;
            chk("t2_ready", 16'(serial_in_ready), 16'd1);
            tick();
            if (k == 8) begin
                chk("t2_w0_valid", 16'(parallel_out_valid), 16'd1);
                chk("t2_w0_data", 16'(parallel_out), 16'h3C);
            end else if (k == 16) begin
                chk("t2_w1_valid", 16'(parallel_out_valid), 16'd1);
                chk("t2_w1_data", 16'(parallel_out), 16'hC3);
            end else begin
                chk("t2_idle", 16'(parallel_out_valid), 16'd0);
            end
        end
        serial_in_valid = 1'b0;
        tick();
        chk("t2_w2_valid", 16'(parallel_out_valid), 16'd1);
        chk("t2_w2_data", 16'(parallel_out), 16'hFF);
        tick();
        chk("t2_w2_drop", 16'(parallel_out_valid), 16'd0);

        // 3: backpressure with 0x12 held and 0x34 in the shift register
        parallel_out_ready = 1'b0;
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        chk("t3_full_ready", 16'(serial_in_ready), 16'd0);
        chk("t3_held_valid", 16'(parallel_out_valid), 16'd1);
        chk("t3_held_data", 16'(parallel_out), 16'h12);
        serial_in = 1'b1;
        tick();
        chk("t3_stall_ready", 16'(serial_in_ready), 16'd0);
        chk("t3_stall_count", 16'(dut.bit_count), 16'd8);
        chk("t3_stall_data", 16'(parallel_out), 16'h12);
        serial_in_valid    = 1'b0;
        parallel_out_ready = 1'b1;
        #1;
        chk("t3_ready_back", 16'(serial_in_ready), 16'd1);
        tick();
        chk("t3_w1_valid", 16'(parallel_out_valid), 16'd1);
        chk("t3_w1_data", 16'(parallel_out), 16'h34);
        tick();
        chk("t3_w1_drop", 16'(parallel_out_valid), 16'd0);

        // 4: freeze mid-word and mid-hold
        send_bits(8'h5A, 4);
        clock_enable    = 1'b0;
        serial_in_valid = 1'b1;
        serial_in       = 1'b1;
        #1;
        chk("t4_frz_ready", 16'(serial_in_ready), 16'd0);
        chk("t4_frz_valid", 16'(parallel_out_valid), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_frz_count", 16'(dut.bit_count), 16'd4);
        end
        clock_enable       = 1'b1;
        parallel_out_ready = 1'b0;
        send_bits(8'hA0, 4);
        serial_in_valid = 1'b0;
        tick();
        chk("t4_word_valid", 16'(parallel_out_valid), 16'd1);
        chk("t4_word_data", 16'(parallel_out), 16'h5A);
        clock_enable       = 1'b0;
        parallel_out_ready = 1'b1;
        #1;
        chk("t4_hold_valid", 16'(parallel_out_valid), 16'd0);
        tick();
        tick();
        tick();
        clock_enable       = 1'b1;
        parallel_out_ready = 1'b0;
        #1;
        chk("t4_kept_valid", 16'(parallel_out_valid), 16'd1);
        chk("t4_kept_data", 16'(parallel_out), 16'h5A);
        parallel_out_ready = 1'b1;
        tick();
        chk("t4_drop", 16'(parallel_out_valid), 16'd0);

        // 5: clear with a held word, then clear while frozen
        parallel_out_ready = 1'b0;
        send_bits(8'h77, 8);
        serial_in_valid = 1'b0;
        tick();
        chk("t5_held", 16'(parallel_out_valid), 16'd1);
        send_bits(8'hC8, 5);
        serial_in_valid = 1'b0;
        clear           = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr_valid", 16'(parallel_out_valid), 16'd0);
        chk("t5_clr_count", 16'(dut.bit_count), 16'd0);
        chk("t5_clr_data", 16'(parallel_out), 16'h00);
        send_bits(8'hE0, 3);
        serial_in_valid = 1'b0;
        clock_enable    = 1'b0;
        clear           = 1'b1;
        tick();
        clear        = 1'b0;
        clock_enable = 1'b1;
        chk("t5_frz_clr_count", 16'(dut.bit_count), 16'd0);
        parallel_out_ready = 1'b1;
        send_bits(8'hC6, 8);
        serial_in_valid = 1'b0;
        tick();
        chk("t5_clean_valid", 16'(parallel_out_valid), 16'd1);
        chk("t5_clean_data", 16'(parallel_out), 16'hC6);
        tick();
        chk("t5_clean_drop", 16'(parallel_out_valid), 16'd0);

        // 6: asynchronous reset between edges
        parallel_out_ready = 1'b0;
        send_bits(8'h99, 8);
        serial_in_valid = 1'b0;
        tick();
        chk("t6_held", 16'(parallel_out_valid), 16'd1);
        send_bits(8'hA0, 4);
        serial_in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", 16'(serial_in_ready), 16'd0);
        chk("t6_rst_valid", 16'(parallel_out_valid), 16'd0);
        chk("t6_rst_data", 16'(parallel_out), 16'h00);
        chk("t6_rst_count", 16'(dut.bit_count), 16'd0);
        tick();
        reset_n            = 1'b1;
        parallel_out_ready = 1'b1;
        send_bits(8'h81, 8);
        serial_in_valid = 1'b0;
        tick();
        chk("t6_word_valid", 16'(parallel_out_valid), 16'd1);
        chk("t6_word_data", 16'(parallel_out), 16'h81);
        tick();
        chk("t6_drop", 16'(parallel_out_valid), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
